mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers for the pipelined MIPS core. Sits in EX beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
- Its `hi`/`lo` outputs feed the d-inputs of the EX result-select 4:1 mux for MFHI/MFLO.
- Its `busy` output feeds the hazard unit, which stalls MD-class instructions while an operation is in flight.

Parameters:
MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk     input   1   clock; all state changes on rising edge
reset   input   1   synchronous, active-low reset (0 = reset)
start   input   1   op valid this cycle
op      input   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
a       input   32  rs operand (dividend / multiplicand / MTxx data)
b       input   32  rt operand (divisor / multiplier)
busy    output  1   registered; operation in flight
hi      output  32  HI register
lo      output  32  LO register

Behaviour:
- Reset, sampled when `reset`=0 at an edge:
  - `hi`=0, `lo`=0, `busy`=0, counter=0.
  - Any in-flight op is discarded; its result is never written.
  - Reset has priority over everything else.
- Accept condition: `start`=1 and `busy`=0 at an edge. If `start`=1 while `busy`=1, the op is ignored and state is unchanged; the hazard unit guarantees this cannot occur, and the bench asserts on it.
- MULT/MULTU:
  - At the accept edge, latch the 64-bit product in a pending register: signed for MULT, unsigned for MULTU.
  - Load counter = MULT_CYCLES.
- DIV/DIVU:
  - At the accept edge, latch quotient→pending LO and remainder→pending HI; load counter = DIV_CYCLES.
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0.
  - Divisor 0: counter still loads and `busy` behaves normally, but at completion `hi`/`lo` stay unchanged.
- MTHI/MTLO:
  - Single cycle: at the accept edge `hi` (or `lo`) ← `a`.
  - `busy` is not raised and the other register is unchanged.
- op 6/7 with `start`=1: no effect.
- Counter and `busy`:
  - `busy` = (counter != 0), registered.
  - Counter decrements by 1 each non-reset edge while nonzero.
  - At the edge where the counter goes 1→0, `hi`/`lo` ← pending values, and `busy` falls at that same edge.
- Latency:
  - `busy` is high for exactly N cycles after the accept edge (N = MULT_CYCLES or DIV_CYCLES).
  - New `hi`/`lo` are visible in the first cycle `busy` is low.
  - A new op may be accepted in that same cycle.
- Visibility: `hi`/`lo` always show committed values; pending results are never visible early. No forwarding from pending.
- Product and quotient are fully computed at the accept edge; the counter only models latency. This keeps the unit deterministic for the bench.
- Back-to-back: a `start` accepted on the cycle `busy` first reads 0 is legal. Results of consecutive ops commit in order.

Test Plan:
- Reset: hold `reset`=0 for 2 cycles, release → `hi`=0, `lo`=0, `busy`=0.
- MULT with a=0xFFFFFFFE (-2), b=3:
  - `busy`=1 for exactly 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - `hi`/`lo` unchanged during the busy window.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV with a=0xFFFFFFF9 (-7), b=2:
  - `busy` for 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Follow with DIVU a=7, b=0 → `hi`/`lo` unchanged after 10 busy cycles.
- MTHI/MTLO, and start while busy:
  - MTHI a=0x12345678 → `hi`=0x12345678 next cycle, `busy` stays 0.
  - Then MULT 2×3, and inside its busy window pulse `start` with MTLO 0xDEAD → ignored; final `lo`=6, `hi`=0.
- Reset mid-op: start DIV 100/7, drive `reset`=0 at busy cycle 4 → `busy`=0, `hi`=`lo`=0, no later write of 14/2.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: bundle between the EX stage and the HI/LO multiply/divide unit.
//   start  op valid this cycle (EX -> unit)
//   op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a      rs operand: dividend / multiplicand / MTHI-MTLO data
//   b      rt operand: divisor / multiplier
//   busy   operation in flight (unit -> hazard unit)
//   hi     committed HI register (unit -> EX result mux)
//   lo     committed LO register (unit -> EX result mux)
// The master modport is the EX-stage side; the slave modport is the unit.
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit with HI/LO registers for the pipelined MIPS
// core. The product or quotient/remainder is computed combinationally at the
// accept edge and parked in a pending register; a down-counter then models
// the unit latency and commits the pending pair into HI/LO when it reaches 0.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset (0 = reset)
//   bus    mdu_hilo_if.slave: start/op/a/b in, busy/hi/lo out
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mdu_hilo_if.slave     bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [3:0]  counter_reg, counter_next;
    logic        busy_reg, busy_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
    logic        commit_reg, commit_next;

    // Arithmetic datapath, evaluated on the current operands.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] quo_u, rem_u;
    logic [31:0] abs_a, abs_b;
    logic [31:0] mag_q, mag_r;
    logic [31:0] quo_s, rem_s;

    always_comb begin
        prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        prod_u = {32'd0, bus.a} * {32'd0, bus.b};

        // A zero divisor is replaced by 1 only to keep the divider well
        // defined; its result is discarded through commit_next.
        div_b = (bus.b == 32'd0) ? 32'd1 : bus.b;
        quo_u = bus.a / div_b;
        rem_u = bus.a % div_b;

        // Signed divide via magnitudes: quotient truncates toward zero and
        // the remainder follows the dividend's sign. 0x80000000 / -1 falls
        // out naturally as quotient 0x80000000, remainder 0.
        abs_a = bus.a[31] ? (32'd0 - bus.a) : bus.a;
        abs_b = div_b[31] ? (32'd0 - div_b) : div_b;
        mag_q = abs_a / abs_b;
        mag_r = abs_a % abs_b;
        quo_s = (bus.a[31] ^ div_b[31]) ? (32'd0 - mag_q) : mag_q;
        rem_s = bus.a[31] ? (32'd0 - mag_r) : mag_r;
    end

    always_comb begin
        counter_next = counter_reg;
        busy_next    = busy_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        commit_next  = commit_reg;

        if (counter_reg != 4'd0) begin
            // In flight: any start here is ignored.
            counter_next = counter_reg - 4'd1;
            if (counter_reg == 4'd1) begin
                busy_next = 1'b0;
                if (commit_reg) begin
                    hi_next = pend_hi_reg;
                    lo_next = pend_lo_reg;
                end
            end
        end else if (bus.start) begin
            case (bus.op)
                OP_MULT: begin
                    pend_hi_next = prod_s[63:32];
                    pend_lo_next = prod_s[31:0];
                    commit_next  = 1'b1;
                    counter_next = 4'(MULT_CYCLES);
                    busy_next    = 1'b1;
                end
                OP_MULTU: begin
                    pend_hi_next = prod_u[63:32];
                    pend_lo_next = prod_u[31:0];
                    commit_next  = 1'b1;
                    counter_next = 4'(MULT_CYCLES);
                    busy_next    = 1'b1;
                end
                OP_DIV: begin
                    pend_hi_next = rem_s;
                    pend_lo_next = quo_s;
                    commit_next  = (bus.b != 32'd0);
                    counter_next = 4'(DIV_CYCLES);
                    busy_next    = 1'b1;
                end
                OP_DIVU: begin
                    pend_hi_next = rem_u;
                    pend_lo_next = quo_u;
                    commit_next  = (bus.b != 32'd0);
                    counter_next = 4'(DIV_CYCLES);
                    busy_next    = 1'b1;
                end
                OP_MTHI: hi_next = bus.a;
                OP_MTLO: lo_next = bus.a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_reg <= 4'd0;
            busy_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            commit_reg  <= 1'b0;
        end else begin
            counter_reg <= counter_next;
            busy_reg    <= busy_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            commit_reg  <= commit_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed-vector bench for mdu_hilo with hand-computed
// expected HI/LO values and busy-window lengths.
module tb_mdu_hilo;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mdu_hilo_if bus ();

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("FAIL %-18s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.op    = OP_NOP;
    endtask

    // Count samples with busy high from now on; HI/LO must hold their
    // previous committed values throughout the window.
    task automatic wait_idle(input string tag, input int exp_cycles,
                             input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        int cnt;
        int leaks;
        cnt   = 0;
        leaks = 0;
        while (bus.busy === 1'b1 && cnt < 40) begin
            if (bus.hi !== hold_hi || bus.lo !== hold_lo) leaks++;
            cnt++;
            step();
        end
        check({tag, "_busylen"}, 32'(cnt), 32'(exp_cycles));
        check({tag, "_hold"}, 32'(leaks), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);

        // MULT -2 * 3 = -6
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult", 5, 32'd0, 32'd0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        // DIV -7 / 2 = -3 rem -1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);

        // Back-to-back DIVU 7 / 0: busy as normal, HI/LO untouched
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divu0_hi", bus.hi, 32'hFFFF_FFFF);
        check("divu0_lo", bus.lo, 32'hFFFF_FFFD);

        // DIV 7 / -2 = -3 rem 1
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle("div_nb", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div_nb_hi", bus.hi, 32'd1);
        check("div_nb_lo", bus.lo, 32'hFFFF_FFFD);

        // DIV 0x80000000 / -1 = 0x80000000 rem 0
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf", 10, 32'd1, 32'hFFFF_FFFD);
        check("div_ovf_hi", bus.hi, 32'd0);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);

        // MTHI: one cycle, no busy, LO untouched
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo", bus.lo, 32'h8000_0000);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);

        // MTLO
        issue(OP_MTLO, 32'h0000_0055, 32'd0);
        check("mtlo_lo", bus.lo, 32'h0000_0055);
        check("mtlo_hi", bus.hi, 32'h1234_5678);

        // op 6 with start: no effect
        issue(OP_NOP, 32'hAAAA_AAAA, 32'h5555_5555);
        check("nop_hi", bus.hi, 32'h1234_5678);
        check("nop_lo", bus.lo, 32'h0000_0055);
        check("nop_busy", {31'd0, bus.busy}, 32'd0);

        // MULT 2*3 with an MTLO pulsed inside the busy window
        issue(OP_MULT, 32'd2, 32'd3);
        step();
        issue(OP_MTLO, 32'h0000_DEAD, 32'd0);
        check("ign_lo", bus.lo, 32'h0000_0055);
        check("ign_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle("ign", 3, 32'h1234_5678, 32'h0000_0055);
        check("ign_hi_fin", bus.hi, 32'd0);
        check("ign_lo_fin", bus.lo, 32'd6);

        // Reset in busy cycle 4 of DIV 100/7
        issue(OP_DIV, 32'd100, 32'd7);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_hi", bus.hi, 32'd0);
        check("mrst_lo", bus.lo, 32'd0);
        repeat (15) step();
        check("mrst_hi_late", bus.hi, 32'd0);
        check("mrst_lo_late", bus.lo, 32'd0);
        check("mrst_busy_late", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
